// File: rtl/timer_multi_par.sv
// Multi-channel modulo timer: NUM_CH channels with per-channel modulus and periodic/one-shot mode,
// all driven by one shared prescaler. Optional sticky rollover flags: define TIMER_STICKY_FLAG_EN.
module timer_multi_par #(
  parameter int  NUM_CH    = 4,
  parameter int  BIT_WIDTH = 16,
  parameter int  PRESCALE  = 1,
  localparam int CH_SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        increment,
  input  logic                        cfg_we,
  input  logic [CH_SEL_W-1:0]         cfg_ch,
  input  logic [BIT_WIDTH-1:0]        cfg_mod,
  input  logic                        cfg_oneshot,
  input  logic [NUM_CH-1:0]           ch_start,
  input  logic [NUM_CH-1:0]           ch_stop,
`ifdef TIMER_STICKY_FLAG_EN
  input  logic [NUM_CH-1:0]           status_clr,
  output logic [NUM_CH-1:0]           status_flag,
`endif
  output logic [NUM_CH*BIT_WIDTH-1:0] count,
  output logic [NUM_CH-1:0]           rolling_over,
  output logic [NUM_CH-1:0]           active
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [PRE_W-1:0]     pre_r;
  logic                 tick_s;
  state_t               state_r   [NUM_CH];
  logic [BIT_WIDTH-1:0] count_r   [NUM_CH];
  logic [BIT_WIDTH-1:0] mod_r     [NUM_CH];
  logic [BIT_WIDTH-1:0] m_eff_s   [NUM_CH];
  logic [NUM_CH-1:0]    oneshot_r;
  logic [NUM_CH-1:0]    active_r;
  logic [NUM_CH-1:0]    term_s;

  // With PRESCALE = 1 the prescaler is pinned at zero, so tick follows increment directly.
  assign tick_s = increment && (pre_r == PRE_LAST);

  // Shared prescaler, free-running on increment regardless of channel states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_r <= {PRE_W{1'b0}};
    end else if (tick_s) begin
      pre_r <= {PRE_W{1'b0}};
    end else if (increment) begin
      pre_r <= pre_r + PRE_W'(1);
    end else begin
      pre_r <= pre_r;
    end
  end

  // Terminal detection; >= lets a channel whose modulus shrank below its count wrap on the next tick.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (mod_r[i] == {BIT_WIDTH{1'b0}}) begin
        m_eff_s[i] = BIT_WIDTH'(1);
      end else begin
        m_eff_s[i] = mod_r[i];
      end
      term_s[i] = tick_s && (state_r[i] == RUN) && !ch_stop[i] && !ch_start[i] &&
                  (count_r[i] >= (m_eff_s[i] - BIT_WIDTH'(1)));
    end
  end

  // Per-channel FSM, counter and configuration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_r[i]   <= IDLE;
        count_r[i]   <= {BIT_WIDTH{1'b0}};
        mod_r[i]     <= BIT_WIDTH'(1);
        oneshot_r[i] <= 1'b0;
        active_r[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_stop[i]) begin
          state_r[i]  <= IDLE;
          active_r[i] <= 1'b0;
        end else if (ch_start[i]) begin
          state_r[i]  <= RUN;
          active_r[i] <= 1'b1;
          count_r[i]  <= {BIT_WIDTH{1'b0}};
        end else begin
          case (state_r[i])
            RUN: begin
              if (term_s[i]) begin
                count_r[i] <= {BIT_WIDTH{1'b0}};
                if (oneshot_r[i]) begin
                  state_r[i]  <= DONE;
                  active_r[i] <= 1'b0;
                end
              end else if (tick_s) begin
                count_r[i] <= count_r[i] + BIT_WIDTH'(1);
              end
            end
            IDLE, DONE: begin
              state_r[i] <= state_r[i];
            end
            default: begin
              state_r[i]  <= IDLE;
              active_r[i] <= 1'b0;
              count_r[i]  <= {BIT_WIDTH{1'b0}};
            end
          endcase
        end
        // Out-of-range cfg_ch never matches any channel index and is dropped.
        if (cfg_we && (int'(cfg_ch) == i)) begin
          mod_r[i]     <= cfg_mod;
          oneshot_r[i] <= cfg_oneshot;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_count
    assign count[g*BIT_WIDTH +: BIT_WIDTH] = count_r[g];
  end

  assign rolling_over = term_s;
  assign active       = active_r;

`ifdef TIMER_STICKY_FLAG_EN
  logic [NUM_CH-1:0] flag_r;

  // Sticky rollover flags; a rollover in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_r <= {NUM_CH{1'b0}};
    end else begin
      flag_r <= (flag_r & ~status_clr) | term_s;
    end
  end

  assign status_flag = flag_r;
`endif

endmodule

// File: tb/tb_timer_multi_par.sv
// Self-checking bench for timer_multi_par: two instances (PRESCALE 1 and 3) share stimulus and are
// compared every cycle against a behavioural channel model; directed scenarios plus random traffic.
module tb_timer_multi_par;
  localparam int NCH = 3;
  localparam int BW  = 8;
  localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2;

  logic clk = 1'b0;
  logic reset;
  logic increment, cfg_we, cfg_oneshot;
  logic [1:0] cfg_ch;
  logic [BW-1:0] cfg_mod;
  logic [NCH-1:0] ch_start, ch_stop;
  logic [NCH*BW-1:0] count_a, count_b;
  logic [NCH-1:0] roll_a, roll_b, act_a, act_b;
  logic [NCH-1:0] last_roll_a, last_roll_b;
`ifdef TIMER_STICKY_FLAG_EN
  logic [NCH-1:0] status_clr, flag_a, flag_b;
`endif

  always #5 clk = ~clk;

  timer_multi_par #(.NUM_CH(NCH), .BIT_WIDTH(BW), .PRESCALE(1)) u_a (
    .clk(clk), .reset(reset), .increment(increment), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mod(cfg_mod), .cfg_oneshot(cfg_oneshot), .ch_start(ch_start), .ch_stop(ch_stop),
`ifdef TIMER_STICKY_FLAG_EN
    .status_clr(status_clr), .status_flag(flag_a),
`endif
    .count(count_a), .rolling_over(roll_a), .active(act_a));

  timer_multi_par #(.NUM_CH(NCH), .BIT_WIDTH(BW), .PRESCALE(3)) u_b (
    .clk(clk), .reset(reset), .increment(increment), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mod(cfg_mod), .cfg_oneshot(cfg_oneshot), .ch_start(ch_start), .ch_stop(ch_stop),
`ifdef TIMER_STICKY_FLAG_EN
    .status_clr(status_clr), .status_flag(flag_b),
`endif
    .count(count_b), .rolling_over(roll_b), .active(act_b));

  int checks = 0;
  int errors = 0;
  int presc [2] = '{1, 3};
  int m_pre [2];
  int m_state [2][NCH];
  int m_cnt [2][NCH];
  int m_mod [2][NCH];
  bit m_os [2][NCH];
  bit m_flag [2][NCH];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_tick(int d);
    return increment && (m_pre[d] == presc[d] - 1);
  endfunction

  function automatic bit m_term(int d, int i);
    int meff;
    meff = (m_mod[d][i] == 0) ? 1 : m_mod[d][i];
    return m_tick(d) && m_state[d][i] == S_RUN && !ch_stop[i] && !ch_start[i] &&
           m_cnt[d][i] >= meff - 1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pre[d] = 0;
      for (int i = 0; i < NCH; i++) begin
        m_state[d][i] = S_IDLE; m_cnt[d][i] = 0; m_mod[d][i] = 1; m_os[d][i] = 0; m_flag[d][i] = 0;
      end
    end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NCH; i++) begin
        check_val($sformatf("roll d%0d ch%0d", d, i), (d == 0) ? roll_a[i] : roll_b[i], m_term(d, i));
        check_val($sformatf("active d%0d ch%0d", d, i), (d == 0) ? act_a[i] : act_b[i],
                  m_state[d][i] == S_RUN);
        check_val($sformatf("count d%0d ch%0d", d, i),
                  (d == 0) ? count_a[i*BW +: BW] : count_b[i*BW +: BW], m_cnt[d][i]);
`ifdef TIMER_STICKY_FLAG_EN
        check_val($sformatf("flag d%0d ch%0d", d, i), (d == 0) ? flag_a[i] : flag_b[i], m_flag[d][i]);
`endif
      end
    end
  endtask

  task automatic model_step();
    bit tk [2];
    bit tm [2][NCH];
    for (int d = 0; d < 2; d++) begin
      tk[d] = m_tick(d);
      for (int i = 0; i < NCH; i++) tm[d][i] = m_term(d, i);
    end
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_stop[i]) m_state[d][i] = S_IDLE;
        else if (ch_start[i]) begin
          m_state[d][i] = S_RUN; m_cnt[d][i] = 0;
        end else if (m_state[d][i] == S_RUN && tk[d]) begin
          if (tm[d][i]) begin
            m_cnt[d][i] = 0;
            if (m_os[d][i]) m_state[d][i] = S_DONE;
          end else m_cnt[d][i] = (m_cnt[d][i] + 1) % 256;
        end
`ifdef TIMER_STICKY_FLAG_EN
        m_flag[d][i] = tm[d][i] | (m_flag[d][i] & !status_clr[i]);
`endif
        if (cfg_we && cfg_ch == i) begin
          m_mod[d][i] = cfg_mod; m_os[d][i] = cfg_oneshot;
        end
      end
      if (increment) m_pre[d] = tk[d] ? 0 : m_pre[d] + 1;
    end
  endtask

  task automatic cyc(input bit inc, input logic [NCH-1:0] st = '0, input logic [NCH-1:0] sp = '0,
                     input bit we = 1'b0, input int ch = 0, input int md = 0, input bit os = 1'b0);
    @(negedge clk);
    increment = inc; ch_start = st; ch_stop = sp; cfg_we = we;
    cfg_ch = 2'(ch); cfg_mod = 8'(md); cfg_oneshot = os;
`ifdef TIMER_STICKY_FLAG_EN
    status_clr = '0;
`endif
    #1;
    check_outputs();
    last_roll_a = roll_a;
    last_roll_b = roll_b;
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; increment = 1'b0; ch_start = '0; ch_stop = '0; cfg_we = 1'b0;
    cfg_ch = 2'd0; cfg_mod = 8'd0; cfg_oneshot = 1'b0;
`ifdef TIMER_STICKY_FLAG_EN
    status_clr = '0;
`endif
    #1;
    model_reset();
    check_outputs();
    #2 reset = 1'b0;
  endtask

  int pos;

  initial begin
    reset = 1'b1;
    increment = 1'b0; ch_start = '0; ch_stop = '0; cfg_we = 1'b0;
    cfg_ch = 2'd0; cfg_mod = 8'd0; cfg_oneshot = 1'b0;
`ifdef TIMER_STICKY_FLAG_EN
    status_clr = '0;
`endif

    // Periodic: M=5, rollovers on increments 5 and 10, count 2 after 12.
    do_reset();
    cyc(1'b0, 3'b000, 3'b000, 1'b1, 0, 5, 1'b0);
    cyc(1'b0, 3'b001);
    pos = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b1);
      if (last_roll_a[0]) pos |= (1 << k);
    end
    check_val("periodic roll positions", pos, (1 << 5) | (1 << 10));
    cyc(1'b0);
    check_val("periodic final count", count_a[BW-1:0], 2);

    // Prescale 3, one-shot M=2 on ch1: single rollover on increment 6, then DONE.
    do_reset();
    cyc(1'b0, 3'b000, 3'b000, 1'b1, 1, 2, 1'b1);
    cyc(1'b0, 3'b010);
    pos = 0;
    for (int k = 1; k <= 9; k++) begin
      cyc(1'b1);
      if (last_roll_b[1]) pos |= (1 << k);
    end
    check_val("oneshot roll positions", pos, 1 << 6);
    cyc(1'b0);
    check_val("oneshot active", act_b[1], 0);
    check_val("oneshot count", count_b[BW +: BW], 0);

    // Stop holds the count, start restarts from zero.
    do_reset();
    cyc(1'b0, 3'b000, 3'b000, 1'b1, 0, 10, 1'b0);
    cyc(1'b0, 3'b001);
    for (int k = 0; k < 3; k++) cyc(1'b1);
    cyc(1'b1, 3'b000, 3'b001);
    for (int k = 0; k < 4; k++) cyc(1'b1);
    cyc(1'b0);
    check_val("stop holds count", count_a[BW-1:0], 3);
    cyc(1'b1, 3'b001);
    cyc(1'b0);
    check_val("restart count", count_a[BW-1:0], 0);

    // Start or stop on a terminal tick suppresses the rollover.
    cyc(1'b0, 3'b000, 3'b000, 1'b1, 0, 2, 1'b0);
    cyc(1'b1);
    cyc(1'b1, 3'b001);
    check_val("start on terminal", last_roll_a[0], 0);
    cyc(1'b1);
    cyc(1'b1, 3'b000, 3'b001);
    check_val("stop on terminal", last_roll_a[0], 0);

    // Shrinking the modulus below the count wraps on the next tick.
    cyc(1'b0, 3'b000, 3'b000, 1'b1, 0, 10, 1'b0);
    cyc(1'b0, 3'b001);
    for (int k = 0; k < 7; k++) cyc(1'b1);
    cyc(1'b0, 3'b000, 3'b000, 1'b1, 0, 4, 1'b0);
    cyc(1'b1);
    check_val("shrink roll", last_roll_a[0], 1);
    cyc(1'b0);
    check_val("shrink count", count_a[BW-1:0], 0);

    // M=0 rolls every tick; out-of-range channel select is ignored.
    cyc(1'b0, 3'b000, 3'b000, 1'b1, 2, 0, 1'b0);
    cyc(1'b0, 3'b000, 3'b000, 1'b1, 3, 7, 1'b1);
    cyc(1'b0, 3'b100);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1);
      check_val("m0 roll", last_roll_a[2], 1);
    end

    // Async reset mid-run clears outputs before the next clock edge.
    do_reset();
    cyc(1'b0, 3'b000, 3'b000, 1'b1, 0, 200, 1'b0);
    cyc(1'b0, 3'b000, 3'b000, 1'b1, 1, 0, 1'b0);
    cyc(1'b0, 3'b011);
    for (int k = 0; k < 5; k++) cyc(1'b1);
    cyc(1'b1);
    check_val("pre-reset roll", roll_a[1], 1);
    #1 reset = 1'b1;
    #1;
    check_val("async count a", count_a, 0);
    check_val("async count b", count_b, 0);
    check_val("async roll a", roll_a, 0);
    check_val("async active a", act_a, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0; increment = 1'b0;

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [NCH-1:0] st, sp;
      for (int i = 0; i < NCH; i++) begin
        st[i] = ($urandom_range(0, 19) == 0);
        sp[i] = ($urandom_range(0, 24) == 0);
      end
      r = $urandom_range(0, 9);
      @(negedge clk);
      increment = ($urandom_range(0, 9) < 7);
      ch_start = st; ch_stop = sp;
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_ch = 2'($urandom_range(0, 3));
      cfg_mod = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(1, 12));
      cfg_oneshot = ($urandom_range(0, 3) == 0);
`ifdef TIMER_STICKY_FLAG_EN
      status_clr = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
`endif
      #1;
      check_outputs();
      model_step();
    end
    cyc(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
